// File: rtl/line_buffer3_if.sv
// Pixel stream in / three-row column out bundle for line_buffer3.
interface line_buffer3_if #(
  parameter int unsigned PIX_W = 12
) ();
  logic [PIX_W-1:0] pix_in;
  logic             pix_valid;
  logic             frame_start;
  logic [PIX_W-1:0] row0_pixel;
  logic [PIX_W-1:0] row1_pixel;
  logic [PIX_W-1:0] row2_pixel;
  logic             row2_pixel_edge;
  logic             row_valid;
  logic             line_err;

  modport master (
    output pix_in, pix_valid, frame_start,
    input  row0_pixel, row1_pixel, row2_pixel, row2_pixel_edge, row_valid, line_err
  );

  modport slave (
    input  pix_in, pix_valid, frame_start,
    output row0_pixel, row1_pixel, row2_pixel, row2_pixel_edge, row_valid, line_err
  );
endinterface

// File: rtl/line_buffer3.sv
// Raster-to-column line buffer: keeps the two previous lines and emits a vertically
// aligned 3-pixel column per accepted pixel, one cycle later.
module line_buffer3 #(
  parameter int unsigned IMG_WIDTH = 640,
  parameter int unsigned PIX_W     = 12
) (
  input logic           clk,
  input logic           rst,
  line_buffer3_if.slave bus
);

  localparam int unsigned ColW     = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [ColW-1:0] ColLast = ColW'(IMG_WIDTH - 1);
  localparam logic [1:0] LinesFull = 2'd2;

  // Line memories are never reset; line_cnt gates their use instead.
  logic [PIX_W-1:0] line_a_mem [IMG_WIDTH];
  logic [PIX_W-1:0] line_b_mem [IMG_WIDTH];

  logic [ColW-1:0]  col_q, col_d;
  logic [1:0]       line_cnt_q, line_cnt_d;
  logic [PIX_W-1:0] row0_q, row0_d;
  logic [PIX_W-1:0] row1_q, row1_d;
  logic [PIX_W-1:0] row2_q, row2_d;
  logic             edge_q, edge_d;
  logic             row_valid_q, row_valid_d;
  logic             line_err_q, line_err_d;

  logic [ColW-1:0]  addr;
  logic             at_last;

  always_comb begin
    // frame_start forces the pixel into column 0 regardless of the running count
    addr        = bus.frame_start ? '0 : col_q;
    at_last     = (addr == ColLast);
    col_d       = col_q;
    line_cnt_d  = line_cnt_q;
    row0_d      = row0_q;
    row1_d      = row1_q;
    row2_d      = row2_q;
    edge_d      = edge_q;
    row_valid_d = 1'b0;
    line_err_d  = 1'b0;
    if (bus.pix_valid) begin
      row0_d = line_b_mem[addr];
      row1_d = line_a_mem[addr];
      row2_d = bus.pix_in;
      edge_d = (addr == '0) || at_last;
      col_d  = at_last ? '0 : addr + ColW'(1);
      if (bus.frame_start) begin
        line_cnt_d = 2'd0;
        line_err_d = (col_q != '0);
      end else begin
        row_valid_d = (line_cnt_q == LinesFull);
        if (at_last && (line_cnt_q != LinesFull)) begin
          line_cnt_d = line_cnt_q + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q       <= '0;
      line_cnt_q  <= '0;
      row0_q      <= '0;
      row1_q      <= '0;
      row2_q      <= '0;
      edge_q      <= 1'b0;
      row_valid_q <= 1'b0;
      line_err_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      line_cnt_q  <= line_cnt_d;
      row0_q      <= row0_d;
      row1_q      <= row1_d;
      row2_q      <= row2_d;
      edge_q      <= edge_d;
      row_valid_q <= row_valid_d;
      line_err_q  <= line_err_d;
    end
  end

  // Read-before-write: the output registers above capture the old contents.
  always_ff @(posedge clk) begin
    if (bus.pix_valid) begin
      line_b_mem[addr] <= line_a_mem[addr];
      line_a_mem[addr] <= bus.pix_in;
    end
  end

  assign bus.row0_pixel      = row0_q;
  assign bus.row1_pixel      = row1_q;
  assign bus.row2_pixel      = row2_q;
  assign bus.row2_pixel_edge = edge_q;
  assign bus.row_valid       = row_valid_q;
  assign bus.line_err        = line_err_q;

endmodule

// File: tb/tb_line_buffer3.sv
// Bench for line_buffer3 (IMG_WIDTH=4): directed scenarios plus random traffic, each
// checked against a model that recalls pixel history by raster position.
module tb_line_buffer3;
  localparam int unsigned W  = 4;
  localparam int unsigned PW = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  line_buffer3_if #(.PIX_W(PW)) bus ();
  line_buffer3 #(.IMG_WIDTH(W), .PIX_W(PW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    int            col;
    logic [PW-1:0] pix;
  } wr_t;

  wr_t           wr_log[$];
  int            n_acc;
  logic          exp_valid, exp_err, exp_edge, r0k, r1k;
  logic [PW-1:0] exp_r0, exp_r1, exp_r2;
  int            checks = 0;
  int            failures = 0;
  logic [3*PW:0] trace_fill[$];
  logic [3*PW:0] trace_gap[$];

  task automatic model_reset();
    n_acc = 0;
    exp_valid = 1'b0; exp_err = 1'b0; exp_edge = 1'b0;
    exp_r0 = '0; exp_r1 = '0; exp_r2 = '0;
    r0k = 1'b1; r1k = 1'b1;
  endtask

  // Pixel position comes from the count since frame start; rows above are the
  // two most recent pixels ever written at the same column.
  task automatic model_accept(input logic fs, input logic [PW-1:0] pix);
    int  c, line, hits;
    wr_t w;
    if (fs) begin
      exp_err = ((n_acc % W) != 0);
      n_acc   = 0;
    end else begin
      exp_err = 1'b0;
    end
    c = n_acc % W;
    line = n_acc / W;
    hits = 0; r0k = 1'b0; r1k = 1'b0;
    for (int i = wr_log.size() - 1; i >= 0 && hits < 2; i--) begin
      if (wr_log[i].col == c) begin
        if (hits == 0) begin exp_r1 = wr_log[i].pix; r1k = 1'b1; end
        else begin exp_r0 = wr_log[i].pix; r0k = 1'b1; end
        hits++;
      end
    end
    exp_r2    = pix;
    exp_edge  = (c == 0) || (c == W - 1);
    exp_valid = !fs && (line >= 2);
    w.col = c; w.pix = pix;
    wr_log.push_back(w);
    n_acc++;
  endtask

  task automatic drive(input logic v, input logic fs, input logic [PW-1:0] p);
    @(negedge clk);
    bus.pix_valid = v; bus.frame_start = fs; bus.pix_in = p;
    @(posedge clk);
    #1;
    if (v) model_accept(fs, p);
    else begin exp_valid = 1'b0; exp_err = 1'b0; end
  endtask

  task automatic test_reset();
    bus.pix_valid = 1'b0; bus.frame_start = 1'b0; bus.pix_in = '0;
    #2 rst = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({bus.row0_pixel, bus.row1_pixel, bus.row2_pixel, bus.row2_pixel_edge,
         bus.row_valid, bus.line_err} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got r0=%0d r1=%0d r2=%0d edge=%b valid=%b err=%b want all 0",
               bus.row0_pixel, bus.row1_pixel, bus.row2_pixel, bus.row2_pixel_edge,
               bus.row_valid, bus.line_err);
    end
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, PW'($urandom));
      checks++;
      if (bus.row_valid !== 1'b0 || bus.line_err !== 1'b0) begin
        failures++;
        $display("FAIL idle_after_reset cyc=%0d valid=%b err=%b want 0 0", i, bus.row_valid,
                 bus.line_err);
      end
    end
  endtask

  task automatic test_fill();
    int nvalid = 0;
    for (int p = 0; p < 16; p++) begin
      drive(1'b1, p == 0, PW'(p));
      checks++;
      if (bus.row_valid !== exp_valid || bus.line_err !== exp_err ||
          bus.row2_pixel_edge !== exp_edge || bus.row2_pixel !== exp_r2) begin
        failures++;
        $display("FAIL fill_ctrl p=%0d got v=%b e=%b edge=%b r2=%0d want v=%b e=%b edge=%b r2=%0d",
                 p, bus.row_valid, bus.line_err, bus.row2_pixel_edge, bus.row2_pixel,
                 exp_valid, exp_err, exp_edge, exp_r2);
      end
      if (exp_valid) begin
        checks++;
        if (bus.row0_pixel !== exp_r0 || bus.row1_pixel !== exp_r1) begin
          failures++;
          $display("FAIL fill_rows p=%0d got r0=%0d r1=%0d want r0=%0d r1=%0d", p,
                   bus.row0_pixel, bus.row1_pixel, exp_r0, exp_r1);
        end
      end
      if (bus.row_valid === 1'b1) begin
        nvalid++;
        trace_fill.push_back({bus.row0_pixel, bus.row1_pixel, bus.row2_pixel,
                              bus.row2_pixel_edge});
      end
      if (p == 8 || p == 10) begin
        checks++;
        if (bus.row_valid !== 1'b1 || bus.row0_pixel !== PW'(p - 8) ||
            bus.row1_pixel !== PW'(p - 4) || bus.row2_pixel !== PW'(p) ||
            bus.row2_pixel_edge !== (p == 8)) begin
          failures++;
          $display("FAIL fill_spot p=%0d got v=%b r0=%0d r1=%0d r2=%0d edge=%b want 1 %0d %0d %0d %b",
                   p, bus.row_valid, bus.row0_pixel, bus.row1_pixel, bus.row2_pixel,
                   bus.row2_pixel_edge, p - 8, p - 4, p, p == 8);
        end
      end
    end
    checks++;
    if (nvalid != 8) begin
      failures++;
      $display("FAIL fill_count got %0d valid outputs want 8", nvalid);
    end
  endtask

  task automatic test_gapped();
    int p = 0;
    for (int i = 0; i < 32; i++) begin
      if (i % 2 == 1) drive(1'b0, 1'b0, PW'($urandom));
      else begin drive(1'b1, p == 0, PW'(p)); p++; end
      checks++;
      if (bus.row_valid !== exp_valid || bus.row2_pixel !== exp_r2 ||
          bus.row2_pixel_edge !== exp_edge || (r1k && bus.row1_pixel !== exp_r1) ||
          (r0k && bus.row0_pixel !== exp_r0)) begin
        failures++;
        $display("FAIL gapped i=%0d got v=%b r0=%0d r1=%0d r2=%0d edge=%b want v=%b r0=%0d r1=%0d r2=%0d edge=%b",
                 i, bus.row_valid, bus.row0_pixel, bus.row1_pixel, bus.row2_pixel,
                 bus.row2_pixel_edge, exp_valid, exp_r0, exp_r1, exp_r2, exp_edge);
      end
      if (bus.row_valid === 1'b1) begin
        trace_gap.push_back({bus.row0_pixel, bus.row1_pixel, bus.row2_pixel,
                             bus.row2_pixel_edge});
      end
    end
    checks++;
    if (trace_gap.size() != trace_fill.size() || trace_fill.size() != 8) begin
      failures++;
      $display("FAIL gapped_len got %0d want %0d (8)", trace_gap.size(), trace_fill.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (trace_gap[k] !== trace_fill[k]) begin
          failures++;
          $display("FAIL gapped_seq k=%0d got %h want %h", k, trace_gap[k], trace_fill[k]);
        end
      end
    end
  endtask

  task automatic test_edge();
    for (int p = 0; p < 12; p++) begin
      drive(1'b1, p == 0, PW'(50 + p));
      if (p >= 8) begin
        checks++;
        if (bus.row_valid !== 1'b1 || bus.row2_pixel_edge !== (p == 8 || p == 11)) begin
          failures++;
          $display("FAIL edge p=%0d got v=%b edge=%b want 1 %b", p, bus.row_valid,
                   bus.row2_pixel_edge, p == 8 || p == 11);
        end
      end
    end
  endtask

  task automatic test_mid_frame();
    int errs = 0;
    int first = -1;
    for (int p = 0; p < 6; p++) drive(1'b1, p == 0, PW'(p));
    drive(1'b1, 1'b1, PW'(100));
    checks++;
    if (bus.line_err !== 1'b1 || bus.row_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_fs_err got err=%b v=%b want 1 0", bus.line_err, bus.row_valid);
    end
    for (int k = 1; k <= 10; k++) begin
      drive(1'b1, 1'b0, PW'(100 + k));
      if (bus.line_err === 1'b1) errs++;
      checks++;
      if (bus.row_valid !== exp_valid || (exp_valid && (bus.row0_pixel !== exp_r0 ||
          bus.row1_pixel !== exp_r1 || bus.row2_pixel !== exp_r2))) begin
        failures++;
        $display("FAIL mid_after k=%0d got v=%b r0=%0d r1=%0d r2=%0d want v=%b r0=%0d r1=%0d r2=%0d",
                 k, bus.row_valid, bus.row0_pixel, bus.row1_pixel, bus.row2_pixel,
                 exp_valid, exp_r0, exp_r1, exp_r2);
      end
      if (first < 0 && bus.row_valid === 1'b1) begin
        first = k;
        checks++;
        if (bus.row0_pixel !== PW'(100) || bus.row1_pixel !== PW'(104)) begin
          failures++;
          $display("FAIL mid_first got r0=%0d r1=%0d want 100 104", bus.row0_pixel,
                   bus.row1_pixel);
        end
      end
    end
    checks++;
    if (errs != 0 || first != 8) begin
      failures++;
      $display("FAIL mid_pulse got extra_err=%0d first_valid_k=%0d want 0 8", errs, first);
    end
  endtask

  task automatic test_async_reset();
    int nvalid = 0;
    for (int p = 0; p < 14; p++) drive(1'b1, p == 0, PW'(200 + p));
    #3 rst = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({bus.row0_pixel, bus.row1_pixel, bus.row2_pixel, bus.row2_pixel_edge,
         bus.row_valid} !== '0) begin
      failures++;
      $display("FAIL async_reset got r0=%0d r1=%0d r2=%0d edge=%b v=%b want all 0",
               bus.row0_pixel, bus.row1_pixel, bus.row2_pixel, bus.row2_pixel_edge,
               bus.row_valid);
    end
    bus.pix_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    for (int p = 0; p < 16; p++) begin
      drive(1'b1, p == 0, PW'(300 + p));
      if (bus.row_valid === 1'b1) nvalid++;
      checks++;
      if (bus.row_valid !== exp_valid || bus.row_valid !== (p >= 8) ||
          (exp_valid && (bus.row0_pixel !== exp_r0 || bus.row1_pixel !== exp_r1))) begin
        failures++;
        $display("FAIL post_reset p=%0d got v=%b r0=%0d r1=%0d want v=%b r0=%0d r1=%0d", p,
                 bus.row_valid, bus.row0_pixel, bus.row1_pixel, exp_valid, exp_r0, exp_r1);
      end
    end
    checks++;
    if (nvalid != 8) begin
      failures++;
      $display("FAIL post_reset_count got %0d want 8", nvalid);
    end
  endtask

  task automatic test_random();
    logic v, fs;
    for (int i = 0; i < 400; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      fs = v && ($urandom_range(0, 30) == 0);
      drive(v, fs, PW'($urandom));
      checks++;
      if (bus.row_valid !== exp_valid || bus.line_err !== exp_err ||
          bus.row2_pixel !== exp_r2 || bus.row2_pixel_edge !== exp_edge ||
          (r1k && bus.row1_pixel !== exp_r1) || (r0k && bus.row0_pixel !== exp_r0)) begin
        failures++;
        $display("FAIL random i=%0d got v=%b e=%b r0=%0d r1=%0d r2=%0d edge=%b want v=%b e=%b r0=%0d r1=%0d r2=%0d edge=%b",
                 i, bus.row_valid, bus.line_err, bus.row0_pixel, bus.row1_pixel,
                 bus.row2_pixel, bus.row2_pixel_edge, exp_valid, exp_err, exp_r0, exp_r1,
                 exp_r2, exp_edge);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_gapped();
    test_edge();
    test_mid_frame();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
